// File: rtl/serial_bit_feeder_if.sv
// Handshake and serial-stream bundle between an upstream word source, the
// serial_bit_feeder, and the sequence detector it feeds.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Data_In;
  logic             Load_Valid;
  logic             Load_Ready;
  logic             Serial_Out;
  logic             Bit_Valid;
  logic             Busy;
  logic             Word_Done;

  modport master (
    output Data_In, Load_Valid,
    input  Load_Ready, Serial_Out, Bit_Valid, Busy, Word_Done
  );

  modport slave (
    input  Data_In, Load_Valid,
    output Load_Ready, Serial_Out, Bit_Valid, Busy, Word_Done
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word on valid/ready and
// shifts it out one bit per clock, with an optional idle gap between words.
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   GAP       = 0,
  parameter logic IDLE_BIT  = 1'b0,
  parameter bit   MSB_FIRST = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst,
  serial_bit_feeder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    LAST_GAP = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg, shreg_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic              serial_q, serial_nxt;
  logic              bit_valid_q, bit_valid_nxt;
  logic              busy_q, busy_nxt;
  logic              word_done_q, word_done_nxt;

  logic              last_bit;
  logic              last_gap;
  logic              ready;
  logic              load;

  // bit_cnt indexes the bit currently on Serial_Out, so "last bit" is the
  // cycle in which the final bit is already being driven.
  assign last_bit = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
  assign last_gap = (state == S_GAP) && (gap_cnt == LAST_GAP);
  assign ready    = (state == S_IDLE) || (last_bit && (GAP == 0)) || last_gap;
  assign load     = bus.Load_Valid && ready;

  assign bus.Load_Ready = ready;
  assign bus.Serial_Out = serial_q;
  assign bus.Bit_Valid  = bit_valid_q;
  assign bus.Busy       = busy_q;
  assign bus.Word_Done  = word_done_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      serial_q    <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      serial_q    <= serial_nxt;
      bit_valid_q <= bit_valid_nxt;
      busy_q      <= busy_nxt;
      word_done_q <= word_done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (load) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) begin
          if (load)         state_nxt = S_SHIFT;
          else if (GAP > 0) state_nxt = S_GAP;
          else              state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (last_gap) state_nxt = load ? S_SHIFT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so this process computes their next values; the
  // first bit of a new word is taken straight from Data_In on the load edge.
  always_comb begin
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    gap_cnt_nxt   = gap_cnt;
    serial_nxt    = IDLE_BIT;
    bit_valid_nxt = 1'b0;
    busy_nxt      = (state_nxt != S_IDLE);

    if (load) begin
      serial_nxt    = MSB_FIRST ? bus.Data_In[WIDTH-1] : bus.Data_In[0];
      shreg_nxt     = MSB_FIRST ? (bus.Data_In << 1) : (bus.Data_In >> 1);
      bit_cnt_nxt   = '0;
      gap_cnt_nxt   = '0;
      bit_valid_nxt = 1'b1;
    end else begin
      unique case (state)
        S_SHIFT: begin
          if (last_bit) begin
            bit_cnt_nxt = '0;
            gap_cnt_nxt = '0;
          end else begin
            serial_nxt    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            shreg_nxt     = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            bit_cnt_nxt   = bit_cnt + CW'(1);
            bit_valid_nxt = 1'b1;
          end
        end
        S_GAP: begin
          gap_cnt_nxt = last_gap ? 4'd0 : gap_cnt + 4'd1;
        end
        default: ;
      endcase
    end

    word_done_nxt = bit_valid_nxt && (bit_cnt_nxt == LAST_BIT);
  end

endmodule
